// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared state encodings and ALU control codes for the ALU arbiter
package alu_arbiter_pkg;
  typedef enum logic [1:0] {
    kSAIL_ALU_ARB_STATE_IDLE    = 2'd0,
    kSAIL_ALU_ARB_STATE_EXEC    = 2'd1,
    kSAIL_ALU_ARB_STATE_CAPTURE = 2'd2
  } alu_arb_state_e;
  localparam logic [3:0] ALUCTL_ADD = 4'h0;
  localparam logic [3:0] ALUCTL_SUB = 4'h1;
  localparam logic [3:0] ALUCTL_XOR = 4'h4;
  localparam logic [2:0] ALUCTL_BR_NONE = 3'd0;
  localparam logic [2:0] ALUCTL_BR_EQ   = 3'd1;
  localparam logic [2:0] ALUCTL_BR_NE   = 3'd2;
  localparam logic [2:0] ALUCTL_BR_LT   = 3'd4;
  localparam logic [2:0] ALUCTL_BR_GE   = 3'd5;
  localparam logic [2:0] ALUCTL_BR_LTU  = 3'd6;
  localparam logic [2:0] ALUCTL_BR_GEU  = 3'd7;
endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// alu_rr_arbiter: two-way round-robin grant; SAIL_ALU_ARB_FIXED_PRIO_EN makes requester 0 always win
module alu_rr_arbiter (
  input  logic elig0,
  input  logic elig1,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);
  always_comb begin
    grant_valid = elig0 || elig1;
`ifdef SAIL_ALU_ARB_FIXED_PRIO_EN
    grant = !elig0;
`else
    grant = (elig0 && elig1) ? !last_grant : elig1;
`endif
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters (optional SAIL_ALU_ARB_FIXED_PRIO_EN)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [6:0]      req0_ctl,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_result,
  output logic            resp0_branch,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [6:0]      req1_ctl,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_result,
  output logic            resp1_branch,
  output logic [6:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_branch,
  output logic            busy
);
  alu_arb_state_e state, state_nxt;
  logic [2:0] cnt;
  logic owner, last_grant, grant, grant_valid, elig0, elig1, accept, cap0, cap1;
  assign elig0 = req0_valid && (!resp0_valid || resp0_ready);
  assign elig1 = req1_valid && (!resp1_valid || resp1_ready);
  alu_rr_arbiter u_arb (
    .elig0       (elig0),
    .elig1       (elig1),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );
  assign busy       = state != kSAIL_ALU_ARB_STATE_IDLE;
  assign accept     = !busy && grant_valid;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign cap0       = state == kSAIL_ALU_ARB_STATE_CAPTURE && !owner;
  assign cap1       = state == kSAIL_ALU_ARB_STATE_CAPTURE && owner;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == kSAIL_ALU_ARB_STATE_IDLE) ? (accept ? kSAIL_ALU_ARB_STATE_EXEC : kSAIL_ALU_ARB_STATE_IDLE) :
                (state == kSAIL_ALU_ARB_STATE_EXEC) ? (cnt == 3'd1 ? kSAIL_ALU_ARB_STATE_CAPTURE : kSAIL_ALU_ARB_STATE_EXEC) :
                kSAIL_ALU_ARB_STATE_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= kSAIL_ALU_ARB_STATE_IDLE;
    else state <= state_nxt;
  // Operands stay registered through CAPTURE and IDLE so the live branch compare sees the issued values
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_ctl    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_ctl    <= grant ? req1_ctl : req0_ctl;
      alu_a      <= grant ? req1_a : req0_a;
      alu_b      <= grant ? req1_b : req0_b;
      cnt        <= 3'(LATENCY);
      owner      <= grant;
      last_grant <= grant;
    end else if (state == kSAIL_ALU_ARB_STATE_EXEC) begin
      cnt <= cnt - 3'd1;
    end
  // A capture in the same cycle as a drain wins, keeping the new response valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp0_branch <= 1'b0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      resp1_branch <= 1'b0;
    end else begin
      resp0_valid <= cap0 || (resp0_valid && !resp0_ready);
      resp1_valid <= cap1 || (resp1_valid && !resp1_ready);
      if (cap0) begin
        resp0_result <= alu_out;
        resp0_branch <= alu_branch;
      end
      if (cap1) begin
        resp1_result <= alu_out;
        resp1_branch <= alu_branch;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a one-stage registered ALU model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
`ifdef SAIL_ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req0_ready, resp0_valid, resp0_ready = 0, resp0_branch;
  logic req1_valid = 0, req1_ready, resp1_valid, resp1_ready = 0, resp1_branch;
  logic [6:0] req0_ctl = '0, req1_ctl = '0, alu_ctl;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] resp0_result, resp1_result, alu_a, alu_b, alu_out;
  logic alu_branch, busy;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_branch(resp0_branch),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_branch(resp1_branch),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_branch(alu_branch), .busy(busy)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) alu_out <= '0;
    else alu_out <= (alu_ctl[3:0] == ALUCTL_ADD) ? alu_a + alu_b :
                    (alu_ctl[3:0] == ALUCTL_SUB) ? alu_a - alu_b :
                    (alu_ctl[3:0] == ALUCTL_XOR) ? alu_a ^ alu_b : 32'h0;
  assign alu_branch = (alu_ctl[6:4] == ALUCTL_BR_EQ)  ? (alu_a == alu_b) :
                      (alu_ctl[6:4] == ALUCTL_BR_NE)  ? (alu_a != alu_b) :
                      (alu_ctl[6:4] == ALUCTL_BR_LT)  ? ($signed(alu_a) < $signed(alu_b)) :
                      (alu_ctl[6:4] == ALUCTL_BR_GE)  ? ($signed(alu_a) >= $signed(alu_b)) :
                      (alu_ctl[6:4] == ALUCTL_BR_LTU) ? (alu_a < alu_b) :
                      (alu_ctl[6:4] == ALUCTL_BR_GEU) ? (alu_a >= alu_b) : 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run1(input bit i, input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic eb, input string tag);
    @(negedge clk);
    if (i) begin req1_valid = 1; req1_ctl = ctl; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_ctl = ctl; req0_a = a; req0_b = b; end
    #1 chk({tag, "_ready"}, {31'h0, i ? req1_ready : req0_ready}, 32'h1);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    #1 chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, i ? resp1_valid : resp0_valid}, 32'h1);
    chk({tag, "_result"}, i ? resp1_result : resp0_result, er);
    chk({tag, "_branch"}, {31'h0, i ? resp1_branch : resp0_branch}, {31'h0, eb});
  endtask
  initial begin
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_ctl", {25'h0, alu_ctl}, 32'h0);
    chk("rst_resp_valid", {30'h0, resp1_valid, resp0_valid}, 32'h0);
    chk("rst_resp0_result", resp0_result, 32'h0);
    @(negedge clk);
    rst = 0;
    resp0_ready = 1;
    resp1_ready = 1;
    // single ADD on requester 0
    @(negedge clk);
    req0_valid = 1; req0_ctl = {ALUCTL_BR_NONE, ALUCTL_ADD}; req0_a = 5; req0_b = 7;
    #1 chk("add_ready", {31'h0, req0_ready}, 32'h1);
    @(negedge clk);
    req0_valid = 0;
    chk("add_busy", {31'h0, busy}, 32'h1);
    chk("add_alu_a", alu_a, 32'd5);
    @(negedge clk);
    chk("add_not_yet", {31'h0, resp0_valid}, 32'h0);
    @(negedge clk);
    chk("add_valid", {31'h0, resp0_valid}, 32'h1);
    chk("add_result", resp0_result, 32'd12);
    chk("add_resp1_quiet", {31'h0, resp1_valid}, 32'h0);
    chk("add_idle", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("add_drained", {31'h0, resp0_valid}, 32'h0);
    // both requesters from reset: alternate grants
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    req0_valid = 1; req0_ctl = {ALUCTL_BR_NONE, ALUCTL_SUB}; req0_a = 10; req0_b = 3;
    req1_valid = 1; req1_ctl = {ALUCTL_BR_NONE, ALUCTL_XOR}; req1_a = 32'hFF; req1_b = 32'h0F;
    #1;
    for (int k = 0; k < 5; k++) begin
      automatic bit g = FIXED ? 1'b0 : k[0];
      automatic bit p = FIXED ? 1'b0 : !k[0];
      chk($sformatf("rr%0d_ready0", k), {31'h0, req0_ready}, {31'h0, !g});
      chk($sformatf("rr%0d_ready1", k), {31'h0, req1_ready}, {31'h0, g});
      if (k > 0) begin
        chk($sformatf("rr%0d_resp_valid", k), {31'h0, p ? resp1_valid : resp0_valid}, 32'h1);
        chk($sformatf("rr%0d_resp_result", k), p ? resp1_result : resp0_result, p ? 32'hF0 : 32'd7);
      end
      repeat (3) @(negedge clk);
    end
    req0_valid = 0;
    req1_valid = 0;
    repeat (3) @(negedge clk);
    // branch compares returned from the held operands
    run1(1, {ALUCTL_BR_LT, ALUCTL_SUB}, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b1, "blt");
    run1(1, {ALUCTL_BR_LTU, ALUCTL_SUB}, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b0, "bltu");
    run1(1, {ALUCTL_BR_EQ, ALUCTL_SUB}, 32'd4, 32'd4, 32'd0, 1'b1, "beq");
    // held response blocks requester 0 while requester 1 proceeds
    resp0_ready = 0;
    run1(0, {ALUCTL_BR_NONE, ALUCTL_ADD}, 32'd2, 32'd3, 32'd5, 1'b0, "hold0");
    @(negedge clk);
    req0_valid = 1; req0_ctl = {ALUCTL_BR_NONE, ALUCTL_ADD}; req0_a = 8; req0_b = 8;
    req1_valid = 1; req1_ctl = {ALUCTL_BR_NONE, ALUCTL_XOR}; req1_a = 32'hFF; req1_b = 32'h0F;
    #1 chk("hold_ready0", {31'h0, req0_ready}, 32'h0);
    chk("hold_ready1", {31'h0, req1_ready}, 32'h1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_r1_valid", {31'h0, resp1_valid}, 32'h1);
    chk("hold_r1_result", resp1_result, 32'hF0);
    chk("hold_r0_valid", {31'h0, resp0_valid}, 32'h1);
    chk("hold_r0_stable", resp0_result, 32'd5);
    chk("hold_r0_blocked", {31'h0, req0_ready}, 32'h0);
    @(negedge clk);
    resp0_ready = 1;
    #1 chk("hold_drain_ready", {31'h0, req0_ready}, 32'h1);
    @(negedge clk);
    resp0_ready = 0;
    req0_valid = 0;
    chk("hold_drained", {31'h0, resp0_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("hold2_valid", {31'h0, resp0_valid}, 32'h1);
    chk("hold2_result", resp0_result, 32'd16);
    resp0_ready = 1;
    @(negedge clk);
    // reset during EXEC drops the operation
    req0_valid = 1; req0_ctl = {ALUCTL_BR_NONE, ALUCTL_ADD}; req0_a = 9; req0_b = 9;
    @(negedge clk);
    req0_valid = 0;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1;
    #1 chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_alu_a", alu_a, 32'h0);
    chk("mid_rst_alu_b", alu_b, 32'h0);
    chk("mid_rst_alu_ctl", {25'h0, alu_ctl}, 32'h0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("no_stale", {30'h0, resp1_valid, resp0_valid}, 32'h0);
    run1(0, {ALUCTL_BR_NONE, ALUCTL_ADD}, 32'd1, 32'd1, 32'd2, 1'b0, "post_rst");
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
